piece_controller: RTL and testbench
===================================

// Module: piece_controller
// PURPOSE
//  Sequences the active tetromino through its life: spawn, gravity/left/right checks via the collision unit, lock into board RAM, then a line-clear handshake.
//  Owns the single board-RAM port and muxes its address between the collision unit (reads) and its own lock writer (writes).
//  Sits between the input/tick logic and the collision unit, board RAM and line-clear block.
// PARAMETERS
//  BOARD_W  10  board columns; RAM addr = y*BOARD_W + x
//  BOARD_H  24  board rows (y 0..23)
//  SPAWN_X  4   x anchor loaded at spawn
//  SPAWN_Y  0   y anchor loaded at spawn
//  DATA_W   6   cell colour width; a nonzero cell is occupied
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  reset         in   1  synchronous, active-high
//  start         in   1  pulse: leave IDLE and request first piece
//  tick          in   1  gravity pulse; latched into tick_pend
//  left_req      in   1  pulse; latched into left_pend
//  right_req     in   1  pulse; latched into right_pend
//  next_req      out  1  high while waiting for the next piece
//  next_valid    in   1  next_block/next_color valid; sampled only while next_req=1
//  next_block    in   3  tetromino code
//  next_color    in   6  colour written at lock
//  x_anchor      out  5  active piece x
//  y_anchor      out  6  active piece y
//  block         out  3  active piece code
//  rotation      out  2  active rotation; loaded 0 at spawn
//  col_enable    out  1  collision-unit enable
//  col_left      out  1  horizontal request to the collision unit
//  col_right     out  1  horizontal request to the collision unit
//  col_complete  in   1  collision-unit done pulse
//  col_collision in   1  fall blocked
//  col_x         in   5  proposed x
//  col_y         in   6  proposed y
//  col_ram_addr  in   8  collision-unit read address
//  ram_addr      out  8  board-RAM address; read data reaches the collision unit one cycle later
//  ram_wren      out  1  board-RAM write enable
//  ram_data      out  6  board-RAM write data
//  piece_locked  out  1  1-cycle pulse after the last lock write
//  clear_done    in   1  line-clear block has finished and released the RAM
//  game_over     out  1  sticky until reset
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (x_anchor, y_anchor, block, rotation, ram_*, col_*, next_req, piece_locked, game_over); pending flags cleared.
//  - IDLE: start -> NEXT.
//  - NEXT: next_req=1. On next_valid: x=SPAWN_X, y=SPAWN_Y, block=next_block, latch colour, rotation=0, first_chk=1 -> SELECT.
//  - SELECT: left_pend&right_pend: clear both, no check.
//    - left_pend or right_pend alone: start a horizontal CHECK; left has priority.
//    - Else tick_pend or first_chk: start a gravity CHECK with col_left=col_right=0.
//    - Else stay.
//  - CHECK: col_enable=1 and ram_addr=col_ram_addr; col_left/right held stable.
//    - On col_complete, drop col_enable the next cycle, consume the serviced flag, then:
//    - horizontal: x_anchor<=col_x, y unchanged; tick_pend is not consumed.
//    - gravity, no collision: y_anchor<=col_y.
//    - gravity, collision with first_chk=1 -> GAMEOVER.
//    - gravity, collision otherwise -> LOCK.
//    - Clear first_chk after any gravity check.
//  - RECOVER: exactly one cycle with col_enable=0, which restarts the collision-unit counter, then -> SELECT.
//  - Check latency: 6 enabled cycles, from the col_enable rise through the col_complete pulse, plus 1 RECOVER cycle.
//  - LOCK: 4 cycles, i=0..3: ram_wren=1, ram_data=colour, ram_addr=(y+cy_i)*BOARD_W + x+cx_i, with cx_i/cy_i = coord bits [2i+1:2i].
//    - Then a 1-cycle piece_locked pulse -> WAIT_CLEAR.
//  - WAIT_CLEAR: ram_wren=0, ram_addr=0 (RAM released); clear_done -> NEXT; pending flags cleared.
//  - GAMEOVER: game_over=1; ignore all inputs except reset.
//  - Requests arriving during CHECK, LOCK or WAIT_CLEAR set their pending flag; a repeated pulse does not queue twice.
//  - Arithmetic: ram_addr is computed at 8 bits, wrapping is not permitted (max 23*10+9=239); anchors are never wrapped.
//  - Reset mid-operation: ram_wren and col_enable are 0 the cycle after reset is sampled; partial lock writes are abandoned.
// STRUCTURE
//  - tetris_pkg: BOARD_W, BOARD_H, SPAWN_X, SPAWN_Y, block codes, state enum {IDLE,NEXT,SELECT,CHECK,RECOVER,LOCK,WAIT_CLEAR,GAMEOVER}.
//  - One sub-module: the existing lut instance (block, rotation -> coord_x, coord_y) for lock offsets.
//  - The RAM address/wren mux is inline.
// TESTING
//  1. reset; start; next_valid with block=0, color=6'h05 -> x_anchor=4, y_anchor=0, col_enable=1 one cycle later, col_left=col_right=0.
//  2. Empty board, tick -> after col_complete y_anchor=1, col_enable low for exactly 1 cycle, the next check needs a new tick.
//  3. x_anchor=0, left_req, model returns col_x=0 -> x unchanged; a tick pulsed during that check is serviced next as a gravity check.
//  4. left_req and right_req in the same cycle -> both discarded, col_enable stays 0, anchors unchanged.
//  5. Gravity collision at y=22 with O piece, colour 6'h05 -> 4 writes to the (y+cy)*10+(x+cx) cells, piece_locked pulse, next_req only after clear_done.
//  6. Collision on first check after spawn -> game_over=1 sticky; reset asserted mid-LOCK -> ram_wren=0 the next cycle, state IDLE.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, tetromino codes and the piece controller state type.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 24;
  localparam int unsigned SPAWN_X = 4;
  localparam int unsigned SPAWN_Y = 0;
  localparam int unsigned DATA_W  = 6;

  localparam logic [2:0] BLK_I = 3'd0;
  localparam logic [2:0] BLK_O = 3'd1;
  localparam logic [2:0] BLK_T = 3'd2;
  localparam logic [2:0] BLK_S = 3'd3;
  localparam logic [2:0] BLK_Z = 3'd4;
  localparam logic [2:0] BLK_J = 3'd5;
  localparam logic [2:0] BLK_L = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StNext,
    StSelect,
    StCheck,
    StRecover,
    StLock,
    StWaitClear,
    StGameOver
  } state_e;

endpackage

// File: rtl/piece_controller_lut.sv
// Cell offsets of a tetromino: four (cx, cy) pairs packed two bits per cell,
// cell i in bits [2i+1:2i]. Rotation bit 0 swaps axes, bit 1 mirrors both.
module piece_controller_lut import tetris_pkg::*; (
  input  logic [2:0] block,
  input  logic [1:0] rotation,
  output logic [7:0] coord_x,
  output logic [7:0] coord_y
);

  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [1:0] cx;
  logic [1:0] cy;

  // Rotation-0 shapes
  always_comb begin
    base_x = 8'h00;
    base_y = 8'h00;
    case (block)
      BLK_I: begin base_x = 8'hE4; base_y = 8'h00; end
      BLK_O: begin base_x = 8'h99; base_y = 8'h50; end
      BLK_T: begin base_x = 8'h64; base_y = 8'h40; end
      BLK_S: begin base_x = 8'h49; base_y = 8'h50; end
      BLK_Z: begin base_x = 8'h94; base_y = 8'h50; end
      BLK_J: begin base_x = 8'h90; base_y = 8'h54; end
      BLK_L: begin base_x = 8'h92; base_y = 8'h54; end
      default: begin base_x = 8'h00; base_y = 8'h00; end
    endcase
  end

  // Apply rotation per cell
  always_comb begin
    coord_x = 8'h00;
    coord_y = 8'h00;
    cx      = 2'd0;
    cy      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cx = rotation[0] ? base_y[2*i +: 2] : base_x[2*i +: 2];
      cy = rotation[0] ? base_x[2*i +: 2] : base_y[2*i +: 2];
      if (rotation[1]) begin
        cx = ~cx;
        cy = ~cy;
      end
      coord_x[2*i +: 2] = cx;
      coord_y[2*i +: 2] = cy;
    end
  end

endmodule

// File: rtl/piece_controller.sv
// Active-piece sequencer: spawn, collision checks, lock writes into board RAM
// and the line-clear handshake. Owns the single board-RAM port.
module piece_controller import tetris_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              tick,
  input  logic              left_req,
  input  logic              right_req,
  output logic              next_req,
  input  logic              next_valid,
  input  logic [2:0]        next_block,
  input  logic [DATA_W-1:0] next_color,
  output logic [4:0]        x_anchor,
  output logic [5:0]        y_anchor,
  output logic [2:0]        block,
  output logic [1:0]        rotation,
  output logic              col_enable,
  output logic              col_left,
  output logic              col_right,
  input  logic              col_complete,
  input  logic              col_collision,
  input  logic [4:0]        col_x,
  input  logic [5:0]        col_y,
  input  logic [7:0]        col_ram_addr,
  output logic [7:0]        ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic              piece_locked,
  input  logic              clear_done,
  output logic              game_over
);

  state_e            state;
  logic [DATA_W-1:0] colour;
  logic              tick_pend;
  logic              left_pend;
  logic              right_pend;
  logic              first_chk;
  logic [1:0]        lock_idx;

  logic [7:0] coord_x;
  logic [7:0] coord_y;
  logic [1:0] lock_cx;
  logic [1:0] lock_cy;
  logic [7:0] lock_row;
  logic [7:0] lock_addr;

  piece_controller_lut u_lut (
    .block    (block),
    .rotation (rotation),
    .coord_x  (coord_x),
    .coord_y  (coord_y)
  );

  // Board cell address of the lock write currently in progress
  always_comb begin
    lock_cx   = coord_x[{lock_idx, 1'b0} +: 2];
    lock_cy   = coord_y[{lock_idx, 1'b0} +: 2];
    lock_row  = {2'b00, y_anchor} + {6'b0, lock_cy};
    lock_addr = lock_row * 8'(BOARD_W) + {3'b000, x_anchor} + {6'b0, lock_cx};
  end

  // RAM port mux: collision reads during a check, lock writes, otherwise released
  always_comb begin
    ram_addr = 8'd0;
    ram_wren = 1'b0;
    ram_data = '0;
    if (state == StCheck) begin
      ram_addr = col_ram_addr;
    end else if (state == StLock) begin
      ram_addr = lock_addr;
      ram_wren = 1'b1;
      ram_data = colour;
    end
  end

  // Piece life-cycle FSM with registered outputs and pending request flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      colour       <= '0;
      tick_pend    <= 1'b0;
      left_pend    <= 1'b0;
      right_pend   <= 1'b0;
      first_chk    <= 1'b0;
      lock_idx     <= 2'd0;
      next_req     <= 1'b0;
      x_anchor     <= 5'd0;
      y_anchor     <= 6'd0;
      block        <= 3'd0;
      rotation     <= 2'd0;
      col_enable   <= 1'b0;
      col_left     <= 1'b0;
      col_right    <= 1'b0;
      piece_locked <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      // Pulses latch while a piece is in play; later assignments below consume them
      if (state != StIdle && state != StGameOver) begin
        tick_pend  <= tick_pend | tick;
        left_pend  <= left_pend | left_req;
        right_pend <= right_pend | right_req;
      end
      case (state)
        StIdle: begin
          if (start) begin
            next_req <= 1'b1;
            state    <= StNext;
          end
        end
        StNext: begin
          if (next_valid) begin
            next_req  <= 1'b0;
            x_anchor  <= 5'(SPAWN_X);
            y_anchor  <= 6'(SPAWN_Y);
            block     <= next_block;
            colour    <= next_color;
            rotation  <= 2'd0;
            first_chk <= 1'b1;
            state     <= StSelect;
          end
        end
        // Recover shares the selection so back-to-back checks have a one-cycle gap
        StSelect, StRecover: begin
          if (left_pend && right_pend) begin
            left_pend  <= left_req;
            right_pend <= right_req;
            state      <= StSelect;
          end else if (left_pend || right_pend) begin
            col_enable <= 1'b1;
            col_left   <= left_pend;
            col_right  <= ~left_pend;
            state      <= StCheck;
          end else if (tick_pend || first_chk) begin
            col_enable <= 1'b1;
            col_left   <= 1'b0;
            col_right  <= 1'b0;
            state      <= StCheck;
          end else begin
            state <= StSelect;
          end
        end
        StCheck: begin
          if (col_complete) begin
            col_enable <= 1'b0;
            col_left   <= 1'b0;
            col_right  <= 1'b0;
            state      <= StRecover;
            if (col_left || col_right) begin
              x_anchor <= col_x;
              if (col_left) begin
                left_pend <= left_req;
              end else begin
                right_pend <= right_req;
              end
            end else begin
              tick_pend <= tick;
              first_chk <= 1'b0;
              if (!col_collision) begin
                y_anchor <= col_y;
              end else if (first_chk) begin
                game_over <= 1'b1;
                state     <= StGameOver;
              end else begin
                lock_idx <= 2'd0;
                state    <= StLock;
              end
            end
          end
        end
        StLock: begin
          lock_idx <= lock_idx + 2'd1;
          if (lock_idx == 2'd3) begin
            piece_locked <= 1'b1;
            state        <= StWaitClear;
          end
        end
        StWaitClear: begin
          piece_locked <= 1'b0;
          if (clear_done) begin
            tick_pend  <= 1'b0;
            left_pend  <= 1'b0;
            right_pend <= 1'b0;
            next_req   <= 1'b1;
            state      <= StNext;
          end
        end
        StGameOver: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller with a six-cycle collision-unit model.
module tb_piece_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, tick, left_req, right_req;
  logic       next_req, next_valid;
  logic [2:0] next_block;
  logic [5:0] next_color;
  logic [4:0] x_anchor;
  logic [5:0] y_anchor;
  logic [2:0] block;
  logic [1:0] rotation;
  logic       col_enable, col_left, col_right;
  logic       col_complete, col_collision;
  logic [4:0] col_x;
  logic [5:0] col_y;
  logic [7:0] col_ram_addr;
  logic [7:0] ram_addr;
  logic       ram_wren;
  logic [5:0] ram_data;
  logic       piece_locked, clear_done, game_over;

  int checks = 0;
  int errors = 0;
  int n;
  int k;

  always #5 clk = ~clk;

  piece_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .tick          (tick),
    .left_req      (left_req),
    .right_req     (right_req),
    .next_req      (next_req),
    .next_valid    (next_valid),
    .next_block    (next_block),
    .next_color    (next_color),
    .x_anchor      (x_anchor),
    .y_anchor      (y_anchor),
    .block         (block),
    .rotation      (rotation),
    .col_enable    (col_enable),
    .col_left      (col_left),
    .col_right     (col_right),
    .col_complete  (col_complete),
    .col_collision (col_collision),
    .col_x         (col_x),
    .col_y         (col_y),
    .col_ram_addr  (col_ram_addr),
    .ram_addr      (ram_addr),
    .ram_wren      (ram_wren),
    .ram_data      (ram_data),
    .piece_locked  (piece_locked),
    .clear_done    (clear_done),
    .game_over     (game_over)
  );

  // Collision-unit model: done pulse on the sixth consecutive enabled cycle
  logic [2:0] col_cnt;
  always @(posedge clk) col_cnt <= col_enable ? col_cnt + 3'd1 : 3'd0;
  assign col_complete = col_enable && (col_cnt == 3'd5);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input string tag);
    k = 0;
    while (!col_enable && k < 10) begin
      step();
      k++;
    end
    check(tag, col_enable, 1);
  endtask

  // Runs through an active check; optionally pulses tick on its third cycle
  task automatic run_check(input bit inject, input string tag);
    n = 0;
    while (col_enable && n < 20) begin
      n++;
      tick = inject && (n == 3);
      step();
    end
    tick = 1'b0;
    check(tag, n, 6);
  endtask

  task automatic spawn(input logic [2:0] blk, input logic [5:0] colr);
    next_block = blk;
    next_color = colr;
    next_valid = 1'b1;
    step();
    next_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_left();
    left_req = 1'b1;
    step();
    left_req = 1'b0;
  endtask

  // Checks four lock writes, the piece_locked pulse and the clear handshake
  task automatic check_lock(input logic [31:0] a0, a1, a2, a3, input logic [5:0] colr);
    logic [31:0] exp_addr [4];
    exp_addr[0] = a0;
    exp_addr[1] = a1;
    exp_addr[2] = a2;
    exp_addr[3] = a3;
    for (int i = 0; i < 4; i++) begin
      check("lock_wren", ram_wren, 1);
      check("lock_addr", ram_addr, exp_addr[i]);
      check("lock_data", ram_data, colr);
      step();
    end
    check("locked_pulse", piece_locked, 1);
    check("release_wren", ram_wren, 0);
    check("release_addr", ram_addr, 0);
    step();
    check("locked_once", piece_locked, 0);
    step();
    check("no_next_before_clear", next_req, 0);
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    check("next_after_clear", next_req, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; tick = 1'b0; left_req = 1'b0; right_req = 1'b0;
    next_valid = 1'b0; next_block = 3'd0; next_color = 6'd0;
    col_collision = 1'b0; col_x = 5'd0; col_y = 6'd0; col_ram_addr = 8'h2A;
    clear_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_outs", {x_anchor, y_anchor, block, rotation, col_enable, col_left, col_right,
                         next_req, piece_locked, game_over, ram_wren}, 0);
    check("reset_ram", {ram_addr, ram_data}, 0);

    // 1: spawn I piece, first gravity check starts one cycle later
    pulse_start();
    check("next_req_start", next_req, 1);
    col_y = 6'd1;
    spawn(3'd0, 6'h05);
    check("spawn_anchor", {x_anchor, y_anchor, block, rotation}, {5'd4, 6'd0, 3'd0, 2'd0});
    check("spawn_en_low", col_enable, 0);
    check("spawn_next_drop", next_req, 0);
    step();
    check("first_chk_en", col_enable, 1);
    check("first_chk_dir", {col_left, col_right}, 0);
    check("chk_ram_mux", ram_addr, 8'h2A);
    check("chk_no_wren", ram_wren, 0);
    run_check(1'b0, "first_chk_len");
    check("first_chk_y", y_anchor, 1);

    // 2: tick-driven gravity check, then no recheck without a new tick
    col_y = 6'd2;
    pulse_tick();
    wait_enable("tick_chk_start");
    run_check(1'b0, "tick_chk_len");
    check("tick_chk_y", y_anchor, 2);
    check("tick_chk_x", x_anchor, 4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (col_enable) k++;
      step();
    end
    check("no_recheck", k, 0);

    // 3: left moves to x=0, then a blocked left at x=0 with a tick during it
    col_x = 5'd0;
    pulse_left();
    wait_enable("left_chk_start");
    check("left_dir", {col_left, col_right}, 2'b10);
    run_check(1'b0, "left_chk_len");
    check("left_x", x_anchor, 0);
    check("left_y_kept", y_anchor, 2);
    col_y = 6'd3;
    pulse_left();
    wait_enable("left0_chk_start");
    run_check(1'b1, "left0_chk_len");
    check("left0_x", x_anchor, 0);
    check("left0_y", y_anchor, 2);
    n = 0;
    while (!col_enable && n < 10) begin
      n++;
      step();
    end
    check("recover_gap", n, 1);
    check("grav_after_left", {col_left, col_right}, 0);
    run_check(1'b0, "grav_after_left_len");
    check("grav_after_left_y", y_anchor, 3);

    // 4: simultaneous left and right cancel
    left_req = 1'b1;
    right_req = 1'b1;
    step();
    left_req = 1'b0;
    right_req = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (col_enable) k++;
      step();
    end
    check("lr_cancel_en", k, 0);
    check("lr_cancel_anchor", {x_anchor, y_anchor}, {5'd0, 6'd3});

    // 5a: lock I piece at (0,3)
    col_collision = 1'b1;
    pulse_tick();
    wait_enable("lock_i_start");
    run_check(1'b0, "lock_i_len");
    check_lock(30, 31, 32, 33, 6'h05);

    // 5b: O piece falls to y=22 and locks there
    col_collision = 1'b0;
    col_y = 6'd1;
    spawn(3'd1, 6'h05);
    wait_enable("o_first_start");
    run_check(1'b0, "o_first_len");
    col_y = 6'd22;
    pulse_tick();
    wait_enable("o_fall_start");
    run_check(1'b0, "o_fall_len");
    check("o_y22", y_anchor, 22);
    col_collision = 1'b1;
    pulse_tick();
    wait_enable("o_lock_start");
    run_check(1'b0, "o_lock_len");
    check_lock(225, 226, 235, 236, 6'h05);

    // 6a: collision on the first check after spawn ends the game
    spawn(3'd2, 6'h11);
    wait_enable("go_chk_start");
    run_check(1'b0, "go_chk_len");
    check("game_over_set", game_over, 1);
    tick = 1'b1; left_req = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) step();
    tick = 1'b0; left_req = 1'b0; start = 1'b0;
    check("game_over_sticky", {game_over, col_enable, next_req, ram_wren}, 4'b1000);

    // 6b: reset in the middle of a lock
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("go_cleared", game_over, 0);
    pulse_start();
    col_collision = 1'b0;
    col_y = 6'd1;
    spawn(3'd0, 6'h2A);
    wait_enable("rst_first_start");
    run_check(1'b0, "rst_first_len");
    col_collision = 1'b1;
    pulse_tick();
    wait_enable("rst_lock_start");
    run_check(1'b0, "rst_lock_len");
    check("mid_lock_wren", ram_wren, 1);
    step();
    reset = 1'b1;
    step();
    check("rst_lock_outs", {ram_wren, col_enable, piece_locked, x_anchor, y_anchor}, 0);
    reset = 1'b0;
    col_collision = 1'b0;
    step();
    step();
    check("rst_idle", next_req, 0);
    pulse_start();
    check("rst_restart", next_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
